// File: rtl/rst_seq_ctrl_if.sv
// Soft-reset handshake and sequenced reset outputs of rst_seq_ctrl.
// The master side requests soft resets and consumes the block resets.
// The slave side is the sequencer itself.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 3
) ();
  logic                   Soft_Rst_Req;
  logic                   Soft_Rst_Ack;
  logic [NUM_DOMAINS-1:0] Domain_Rst_n;
  logic                   Rst_Done;

  modport master (
    output Soft_Rst_Req,
    input  Soft_Rst_Ack,
    input  Domain_Rst_n,
    input  Rst_Done
  );

  modport slave (
    input  Soft_Rst_Req,
    output Soft_Rst_Ack,
    output Domain_Rst_n,
    output Rst_Done
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the CLK domain.
// The pad reset is turned into NUM_DOMAINS active-low block resets.
// All block resets are asserted together.
// They are released one at a time in index order, with a fixed gap between releases.
// A software reset request re-runs the same hold/release sequence.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int NUM_Stages  = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int RELEASE_GAP = 4,
  parameter int CNT_W       = 8
) (
  input  logic           CLK,
  input  logic           Async_Reset,
  rst_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  logic [NUM_Stages-1:0]  sync_q;
  logic                   sync_rst_n;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NUM_DOMAINS-1:0] dom_q,   dom_d;
  logic                   done_q,  done_d;
  logic                   ack_q,   ack_d;

  // Internal reset synchronizer: the input is tied high, so the chain shifts ones in after the pad reset releases.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) sync_q <= '0;
    else              sync_q <= {sync_q[NUM_Stages-2:0], 1'b1};
  end

  assign sync_rst_n = sync_q[NUM_Stages-1];

  // Sequencer next-state logic. Everything stays frozen until the synchronized reset releases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    if (sync_rst_n) begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            dom_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.Soft_Rst_Req) begin
            ack_d   = 1'b1;
            dom_d   = '0;
            done_d  = 1'b0;
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state registers. The pad reset forces every block reset asserted at once.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.Soft_Rst_Ack = ack_q;
  assign bus.Domain_Rst_n = dom_q;
  assign bus.Rst_Done     = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl.
// It exercises a default-parameter instance and a minimal instance with one domain and unit hold/gap.
module tb_rst_seq_ctrl;

  logic CLK;
  logic Async_Reset;
  int   checks;
  int   failures;

  rst_seq_ctrl_if #(.NUM_DOMAINS(3)) bus  ();
  rst_seq_ctrl_if #(.NUM_DOMAINS(1)) bus1 ();

  rst_seq_ctrl #(
    .NUM_DOMAINS(3), .NUM_Stages(2), .HOLD_CYCLES(8), .RELEASE_GAP(4), .CNT_W(8)
  ) dut (
    .CLK(CLK), .Async_Reset(Async_Reset), .bus(bus)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS(1), .NUM_Stages(2), .HOLD_CYCLES(1), .RELEASE_GAP(1), .CNT_W(8)
  ) dut1 (
    .CLK(CLK), .Async_Reset(Async_Reset), .bus(bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected Domain_Rst_n t edges into a sequence whose domain 0 releases at edge 'first'.
  function automatic logic [2:0] exp_dom(input int t, input int first);
    if (t < first)          return 3'b000;
    else if (t < first + 4) return 3'b001;
    else if (t < first + 8) return 3'b011;
    else                    return 3'b111;
  endfunction

  // Power-on sequence, with edges counted from the deassertion of Async_Reset.
  task automatic power_on(input int n);
    for (int e = 1; e <= n; e++) begin
      step();
      chk("po_dom",   32'(bus.Domain_Rst_n),  32'(exp_dom(e, 14)));
      chk("po_done",  32'(bus.Rst_Done),      32'(e >= 22));
      chk("po_ack",   32'(bus.Soft_Rst_Ack),  32'd0);
      chk("min_dom",  32'(bus1.Domain_Rst_n), 32'(e >= 4));
      chk("min_done", 32'(bus1.Rst_Done),     32'(e >= 4));
    end
  endtask

  // Soft-reset resequence, with edges counted from the ack edge.
  task automatic soft_seq(input int from, input int upto);
    for (int j = from; j <= upto; j++) begin
      step();
      chk("sr_dom",  32'(bus.Domain_Rst_n), 32'(exp_dom(j, 12)));
      chk("sr_done", 32'(bus.Rst_Done),     32'(j >= 20));
      chk("sr_ack",  32'(bus.Soft_Rst_Ack), 32'd0);
    end
  endtask

  task automatic ack_edge(input string tag);
    step();
    chk({tag, "_ack"},  32'(bus.Soft_Rst_Ack), 32'd1);
    chk({tag, "_dom"},  32'(bus.Domain_Rst_n), 32'd0);
    chk({tag, "_done"}, 32'(bus.Rst_Done),     32'd0);
  endtask

  initial begin
    int j;
    checks   = 0;
    failures = 0;
    bus.Soft_Rst_Req  = 1'b0;
    bus1.Soft_Rst_Req = 1'b0;
    Async_Reset = 1'b0;
    #1;
    chk("rst_dom",  32'(bus.Domain_Rst_n), 32'd0);
    step();
    step();
    chk("rst_dom",  32'(bus.Domain_Rst_n),  32'd0);
    chk("rst_done", 32'(bus.Rst_Done),      32'd0);
    chk("rst_ack",  32'(bus.Soft_Rst_Ack),  32'd0);
    chk("rst_dom1", 32'(bus1.Domain_Rst_n), 32'd0);

    // Test 1 and test 6: power-on with default parameters and with the minimal instance
    Async_Reset = 1'b1;
    power_on(22);

    // Test 2: soft reset accepted in DONE
    bus.Soft_Rst_Req = 1'b1;
    ack_edge("t2");
    bus.Soft_Rst_Req = 1'b0;
    soft_seq(1, 20);

    // Test 3: request raised during RELEASE is held off until DONE
    bus.Soft_Rst_Req = 1'b1;
    ack_edge("t3a");
    bus.Soft_Rst_Req = 1'b0;
    soft_seq(1, 10);
    bus.Soft_Rst_Req = 1'b1;
    soft_seq(11, 20);
    ack_edge("t3b");
    bus.Soft_Rst_Req = 1'b0;
    soft_seq(1, 20);

    // Test 5: request held high for 30 cycles
    bus.Soft_Rst_Req = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      j = (e < 22) ? e - 1 : e - 22;
      chk("t5_ack", 32'(bus.Soft_Rst_Ack), 32'((e == 1) || (e == 22)));
      chk("t5_dom", 32'(bus.Domain_Rst_n), (j == 0) ? 32'd0 : 32'(exp_dom(j, 12)));
      chk("t5_prefix", 32'((bus.Domain_Rst_n == 3'b000) || (bus.Domain_Rst_n == 3'b001) ||
                           (bus.Domain_Rst_n == 3'b011) || (bus.Domain_Rst_n == 3'b111)), 32'd1);
    end
    bus.Soft_Rst_Req = 1'b0;
    soft_seq(9, 20);

    // Test 4: pad reset pulsed mid-sequence
    Async_Reset = 1'b0;
    #1;
    chk("t4_assert_dom", 32'(bus.Domain_Rst_n), 32'd0);
    step();
    Async_Reset = 1'b1;
    power_on(17);
    Async_Reset = 1'b0;
    #1;
    chk("t4_pulse_dom",  32'(bus.Domain_Rst_n), 32'd0);
    chk("t4_pulse_done", 32'(bus.Rst_Done),     32'd0);
    step();
    Async_Reset = 1'b1;
    power_on(22);
    step();
    chk("t4_hold_dom", 32'(bus.Domain_Rst_n), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
